// File: rtl/regfile_mp_pkg.sv
// Shared core definitions: default datapath sizes and the soft-clear FSM state type.
package regfile_mp_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/regfile_mp_clr_seq.sv
// Soft-clear sequencer: walks idx across every register once, then pulses clr_done.
module regfile_clr_seq
  import regfile_mp_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          sweep_en,
  output logic [AW-1:0] sweep_idx
);

  clr_state_e    state_q;
  logic [AW-1:0] idx_q;
  logic          busy_q;
  logic          done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (clr_req) begin
            state_q <= SWEEP;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          // idx wraps back to 0 on the last register, leaving it ready for next time
          idx_q <= idx_q + 1'b1;
          if (idx_q == AW'(NREGS - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy  = busy_q;
  assign clr_done  = done_q;
  assign sweep_en  = (state_q == SWEEP);
  assign sweep_idx = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with x0 hardwired to zero, pending scoreboard and soft clear.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]    rs_busy,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic [AW-1:0]     dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] pending_q;
  logic            sweep_en;
  logic [AW-1:0]   sweep_idx;

  regfile_clr_seq #(
    .NREGS(NREGS),
    .AW   (AW)
  ) u_clr_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .sweep_en (sweep_en),
    .sweep_idx(sweep_idx)
  );

  // x0 is never written with anything but zero, so reads need no address-0 guard
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pending_q <= '0;
    end else begin
      if (sweep_en) begin
        regs_q[sweep_idx]    <= '0;
        pending_q[sweep_idx] <= 1'b0;
      end
      if (!clr_busy) begin
        if (we && (waddr != '0)) begin
          regs_q[waddr]    <= wdata;
          pending_q[waddr] <= 1'b0;
        end
        // later assignment lets a same-cycle allocate override the write's clear
        if (alloc_en && (alloc_addr != '0)) pending_q[alloc_addr] <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[gi*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = we && (waddr != '0) && !clr_busy && (ra == waddr);
    assign rdata[gi*XLEN +: XLEN] = hit ? wdata : regs_q[ra];
    assign rs_busy[gi]            = hit ? 1'b0  : pending_q[ra];
`else
    assign rdata[gi*XLEN +: XLEN] = regs_q[ra];
    assign rs_busy[gi]            = pending_q[ra];
`endif
  end

  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the core datapath: configurable width, depth and read-port count, register 0 hardwired to zero, a per-register pending scoreboard for hazard detection, and a sequenced soft-clear engine. Sits between decode (read and allocate) and writeback (write). A single debug read port gives visibility of every register without one output per register.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; power of two, at least 2.
- NRD, 2, number of read ports.
- AW, $clog2(NREGS), address width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- raddr  in  NRD*AW  read addresses; port k is bits [k*AW +: AW].
- rdata  out  NRD*XLEN  read data; port k is bits [k*XLEN +: XLEN].
- rs_busy  out  NRD  bit k high when the register on read port k has a pending write.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  XLEN  write data.
- alloc_en  in  1  mark a register as pending, issued by decode for its destination register.
- alloc_addr  in  AW  register to mark pending.
- clr_req  in  1  start a soft clear (single-cycle pulse).
- clr_busy  out  1  soft clear in progress.
- clr_done  out  1  one-cycle pulse when the soft clear completes.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  debug read data, combinational, with no bypass.

## Operation
- **Storage:** NREGS x XLEN registers and an NREGS-bit pending vector.
- **Reads:** combinational, `rdata[k] = reg[raddr[k]]`. Address 0 always reads 0.
- **Write:** when `we` is high and `waddr != 0`, `reg[waddr] <= wdata` and `pending[waddr] <= 0`. Writes to address 0 are discarded.
- **Allocate:** when `alloc_en` is high and `alloc_addr != 0`, `pending[alloc_addr] <= 1`. `pending[0]` is constant 0.
- **Allocate and write to the same address in the same cycle:** the allocate wins, so `pending` ends at 1 and the data is still written (a new producer has issued).
- **Busy flag:** `rs_busy[k] = pending[raddr[k]]`.
- **Clear FSM:** states IDLE, SWEEP, DONE.
  - IDLE → SWEEP on `clr_req`; index `idx` is loaded with 0.
  - In SWEEP, each cycle sets `reg[idx] <= 0` and `pending[idx] <= 0`, then increments `idx`. When `idx == NREGS-1` the next state is DONE.
  - DONE → IDLE unconditionally; `clr_done` is 1 in DONE.
  - `clr_busy` is 1 in SWEEP and DONE.
  - While `clr_busy` is high, `we`, `alloc_en` and `clr_req` are ignored. Upstream must stall on `clr_busy`.
  - Reads remain live during the sweep and return partially cleared contents.
- **Reset:** all registers are 0, all pending bits are 0, the FSM is in IDLE and `idx` is 0. Reset in the middle of a sweep aborts it without a `clr_done` pulse.
- **Reset values of outputs:** `rdata` = 0, `dbg_data` = 0, `rs_busy` = 0, `clr_busy` = 0, `clr_done` = 0.

## Timing
- **Read latency:** 0 cycles (combinational from `raddr` and stored state).
- **Write latency:** a write is visible on `rdata` in the cycle after `we`. Same-cycle visibility exists only under REGFILE_BYPASS_EN.
- **Allocate latency:** `rs_busy` rises in the cycle after `alloc_en`.
- **Soft clear duration:**
  - `clr_req` in cycle T: SWEEP occupies T+1 through T+NREGS.
  - DONE, with the `clr_done` pulse, is cycle T+NREGS+1.
  - IDLE, with `clr_busy` low, from T+NREGS+2.
- **Critical path:** the NRD-way NREGS:1 read mux, plus the bypass compare when enabled.

## Configuration
- **REGFILE_BYPASS_EN defined:**
  - Each read port compares `raddr[k]` against `waddr`. If `we` is high, `waddr != 0`, `raddr[k] == waddr` and `clr_busy` is low, then `rdata[k] = wdata` and `rs_busy[k] = 0` in the same cycle.
  - The write-then-read hazard costs zero cycles.
  - Allocate-and-write collision rule is unchanged: the bypass applies only to data and busy for the current cycle.
- **REGFILE_BYPASS_EN undefined:** reads always return stored state, and a read in the write cycle returns the old value with `rs_busy` still 1.
- `dbg_data` never bypasses in either configuration.

## Structure
- **Shared core package:** XLEN default, NREGS default, and the clear FSM state typedef (IDLE/SWEEP/DONE, 2-bit encoding 0/1/2). The writeback and debug blocks use these too.
- **Sub-module `regfile_clr_seq`:** holds the FSM and `idx` counter, and outputs `clr_busy`, `clr_done`, `sweep_en` and `sweep_idx`.
- **Everything else:** storage, pending vector, read mux and bypass stay in `regfile_mp`.

## Test plan
- **Reset, then basic reads:** reset for 2 cycles, then read every address on all ports → 0, `rs_busy` = 0, `clr_busy` = 0.
- **Write and x0 protection:**
  - Write 0xDEADBEEF to x5, then read x5 on port 1 in the next cycle → 0xDEADBEEF.
  - Write 0x1234 to x0 → x0 still reads 0.
- **Scoreboard:**
  - Allocate x7 → `rs_busy` for x7 is 1 from the next cycle.
  - Write x7 = 0x55 → `rs_busy` is 0 in the cycle after; with bypass, it is already 0 in the write cycle and `rdata` = 0x55.
  - Allocate and write x9 in the same cycle → `pending[9]` = 1 and x9 holds the written data.
- **Soft clear with NREGS=32:**
  - Fill x1–x31 with nonzero values and allocate x3, then pulse `clr_req` at cycle T → `clr_busy` high T+1 to T+33, `clr_done` high only at T+33.
  - All registers read 0 and all `rs_busy` are 0 afterwards.
  - A `we` issued at T+10 is dropped.
- **Reset mid-sweep:** assert reset at T+12 → FSM in IDLE, no `clr_done` pulse, all registers 0.
- **Parameter sweep:** XLEN=64, NREGS=16, NRD=3 → each port reads its address independently and address wrap-around covers 0–15.
